// File: rtl/aes_pkg.sv
// AES-128 shared definitions: sizes, round constants, GF(2^8) arithmetic,
// S-box / inverse S-box and the forward / inverse key-expansion steps.
package aes_pkg;

    localparam int unsigned NK = 4;
    localparam int unsigned NR = 10;

    typedef enum logic [2:0] {
        StIdle,
        StExpand,
        StInit,
        StRound,
        StFinal
    } aes_state_e;

    // Rcon table; indices outside 1..10 yield zero.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] e;
        r = 8'h01;
        x = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, x);
            x = gmul(x, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // Round key i -> round key i+1 (word 0 in bits [127:96]).
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Round key i+1 -> round key i; rc is the constant used to build key i+1.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES decryption round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last_i).
module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Round datapath; byte (row r, column c) sits at index 4*c+r, MSB first.
    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(4*c + r) -: 8] = state_i[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        for (int b = 0; b < 16; b++) begin
            subbed[127 - 8*b -: 8] = inv_sbox(shifted[127 - 8*b -: 8]);
        end
        keyed = subbed ^ round_key_i;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_column(keyed[127 - 32*c -: 32]);
        end
        state_o = last_i ? keyed : mixed;
    end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryptor, falling-edge clocked, async active-low reset.
// Expands the cipher key forward to round key 10, then walks it back one step
// per round alongside the inverse cipher rounds.
// Optional macro AES_DEC_KEY_CACHE_EN: keeps the last key and its round-10 key
// so a repeated key skips expansion.
module aes_decrypt_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    aes_state_e        st_q, st_d;
    logic [3:0]        rc_q, rc_d;
    logic [127:0]      state_q, state_d;
    logic [32*NK-1:0]  key_q, key_d;
    logic [127:0]      data_out_q, data_out_d;
    logic              done_q, done_d;

    logic [127:0]      rk_next;
    logic [127:0]      rk_prev;
    logic [127:0]      round_out;
    logic              accept;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_vld_q, cache_vld_d;
    logic         cache_hit;

    assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

    assign rk_next = fwd_key_step(key_q, rcon(rc_q));
    assign rk_prev = inv_key_step(key_q, rcon(4'(rc_q + 4'd1)));

    inv_round u_inv_round (
        .state_i     (state_q),
        .round_key_i (rk_prev),
        .last_i      (st_q == StFinal),
        .state_o     (round_out)
    );

    // Next-state logic; FINAL may accept a new start so blocks run back-to-back.
    always_comb begin
        st_d       = st_q;
        rc_d       = rc_q;
        state_d    = state_q;
        key_d      = key_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        accept     = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
`endif
        unique case (st_q)
            StIdle: accept = start;
            StExpand: begin
                key_d = rk_next;
                if (rc_q == 4'(NR)) begin
                    st_d = StInit;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_rk_d  = rk_next;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    rc_d = 4'(rc_q + 4'd1);
                end
            end
            StInit: begin
                state_d = state_q ^ key_q;
                rc_d    = 4'(NR - 1);
                st_d    = StRound;
            end
            StRound: begin
                key_d   = rk_prev;
                state_d = round_out;
                rc_d    = 4'(rc_q - 4'd1);
                if (rc_q == 4'd1) st_d = StFinal;
            end
            StFinal: begin
                key_d      = rk_prev;
                data_out_d = round_out;
                done_d     = 1'b1;
                st_d       = StIdle;
                accept     = start;
            end
            default: st_d = StIdle;
        endcase

        if (accept) begin
            state_d = data_in;
            key_d   = key;
            rc_d    = 4'd1;
            st_d    = StExpand;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
                key_d = cache_rk_q;
                st_d  = StInit;
            end else begin
                cache_key_d = key;
                cache_vld_d = 1'b0;
            end
`endif
        end
    end

    // State registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= StIdle;
            rc_q       <= '0;
            state_q    <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            rc_q       <= rc_d;
            state_q    <= state_d;
            key_q      <= key_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    // Key cache registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    assign busy     = (st_q != StIdle);
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Scoreboard bench for aes_decrypt_top using FIPS-197 vectors.
module tb_aes_decrypt_top;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int LAT_FULL = 21;
    localparam int LAT_HIT  = 11;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    exp_t         sb_q[$];
    logic [127:0] mdl_key;
    bit           mdl_vld;

    aes_decrypt_top dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .key      (key),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT state moves on negedge; cyc is the index of the latest negedge.
    always @(negedge clk) cyc <= cyc + 1;

    // Expected latency of an accepted block, tracking the key cache when enabled.
    function automatic int lat_model(input logic [127:0] k);
        int lat;
        lat = LAT_FULL;
        if (CacheEn && mdl_vld && (mdl_key == k)) lat = LAT_HIT;
        mdl_key = k;
        mdl_vld = 1'b1;
        return lat;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] pt, input int acc, input int lat);
        exp_t e;
        e.pt  = pt;
        e.acc = acc;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Drive one start pulse; the negedge after this posedge is the accept edge.
    task automatic issue(input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] pt, input bit score);
        @(posedge clk);
        data_in = ct;
        key     = k;
        start   = 1'b1;
        if (score) push_exp(pt, cyc + 1, lat_model(k));
        @(posedge clk);
        start   = 1'b0;
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key     = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: done=%b, required 1", name, done);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected block.
    always @(posedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with data_out=%h, required no done", data_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_out", data_out, e.pt);
                check("latency", 128'(cyc - e.acc), 128'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int l1;
        int l2;
        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        key     = '0;
        mdl_key = '0;
        mdl_vld = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_data_out", data_out, '0);
        @(posedge clk);
        reset = 1'b1;

        // Single blocks
        issue(C1_CT, C1_KEY, C1_PT, 1'b1);
        drain("c1");
        issue(B_CT, B_KEY, B_PT, 1'b1);
        drain("b");

        // Start while busy is ignored
        issue(C1_CT, C1_KEY, C1_PT, 1'b1);
        repeat (4) @(posedge clk);
        data_in = B_CT;
        key     = B_KEY;
        start   = 1'b1;
        @(posedge clk);
        start   = 1'b0;
        check("busy_mid_block", 128'(busy), 128'(1));
        drain("ignore");

        // Reset during a block
        issue(B_CT, B_KEY, B_PT, 1'b1);
        drain("pre_reset");
        issue(C1_CT, C1_KEY, C1_PT, 1'b0);
        repeat (11) @(posedge clk);
        reset   = 1'b0;
        mdl_vld = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_data_out", data_out, '0);
        check("midrst_done", 128'(done), 128'(0));
        repeat (2) @(posedge clk);
        reset = 1'b1;
        repeat (30) @(posedge clk);
        issue(C1_CT, C1_KEY, C1_PT, 1'b1);
        drain("after_reset");

        // Back-to-back: start held high through done
        @(posedge clk);
        data_in = C1_CT;
        key     = C1_KEY;
        start   = 1'b1;
        acc     = cyc + 1;
        l1      = lat_model(C1_KEY);
        push_exp(C1_PT, acc, l1);
        l2      = lat_model(B_KEY);
        push_exp(B_PT, acc + l1, l2);
        @(posedge clk);
        data_in = B_CT;
        key     = B_KEY;
        wait_done("b2b_first");
        start   = 1'b0;
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        drain("b2b");

        // Key cache sequence from a cleared cache
        @(posedge clk);
        reset   = 1'b0;
        mdl_vld = 1'b0;
        @(posedge clk);
        reset = 1'b1;
        issue(C1_CT, C1_KEY, C1_PT, 1'b1);
        drain("cache_c1_a");
        issue(C1_CT, C1_KEY, C1_PT, 1'b1);
        drain("cache_c1_b");
        issue(B_CT, B_KEY, B_PT, 1'b1);
        drain("cache_b");

        repeat (30) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_top.md
AES_DECRYPT_TOP -- requirements
Module: aes_decrypt_top

Interface
REQ-001 The block SHALL have no parameters; the AES-128 sizes are fixed (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state SHALL update on the falling edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to decrypt; sampled only while busy=0.
REQ-005 data_in  input  128  ciphertext block, byte 0 in bits [127:120].
REQ-006 key  input  128  AES-128 cipher key (round-0 key), same byte order.
REQ-007 data_out  output  128  recovered plaintext; held stable until the next done.
REQ-008 busy  output  1  high in every FSM state except IDLE.
REQ-009 done  output  1  one-cycle pulse when data_out is updated.

Function
REQ-010 The FSM SHALL have the states IDLE, EXPAND, INIT, ROUND, FINAL and keep a 4-bit round counter rc.
REQ-011 In IDLE with start=1 the block SHALL capture data_in and key, set rc=1, load the working key with key, and enter EXPAND.
REQ-012 EXPAND SHALL apply one forward key-expansion step per cycle with Rcon(rc) for rc=1..10, then enter INIT holding round key 10.
REQ-013 INIT SHALL set state = ciphertext XOR key10, set rc=9, and enter ROUND.
REQ-014 Each ROUND cycle SHALL derive key[rc] from key[rc+1] by inverse expansion with Rcon(rc+1).
REQ-015 Each ROUND cycle SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(key[rc]) and InvMixColumns, then decrement rc.
REQ-016 ROUND SHALL exit to FINAL after rc=1.
REQ-017 FINAL SHALL derive key0 and apply InvShiftRows, InvSubBytes and AddRoundKey(key0) without InvMixColumns.
REQ-018 FINAL SHALL write the result to data_out, pulse done and return to IDLE.
REQ-019 Latency from the start-accept edge to the done edge SHALL be 21 cycles (10 EXPAND + 1 INIT + 9 ROUND + 1 FINAL).
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the block in flight.
REQ-021 start in the same cycle as done SHALL be accepted, giving back-to-back blocks with no idle gap.
REQ-022 data_in and key SHALL be don't-care after the accept edge; the block SHALL use only the captured copies.
REQ-023 Round-constant arithmetic SHALL be GF(2^8) with polynomial 0x11B; rc SHALL never wrap past 10 or below 0.

Reset
REQ-024 reset=0 SHALL immediately force IDLE and clear rc, the working state, the working key, data_out, busy and done to 0.
REQ-025 Reset mid-operation SHALL abandon the block and SHALL NOT produce a done pulse; the first start after release SHALL behave as a fresh request.

Configuration
REQ-026 With AES_DEC_KEY_CACHE_EN defined, the block SHALL store the last key and its round-10 key plus a valid flag.
REQ-027 With AES_DEC_KEY_CACHE_EN defined, a start whose key equals the cached valid key SHALL skip EXPAND and go straight to INIT, giving 11-cycle latency.
REQ-028 With AES_DEC_KEY_CACHE_EN defined, a key mismatch SHALL run EXPAND and refresh the cache at the end of EXPAND.
REQ-029 With AES_DEC_KEY_CACHE_EN defined, reset SHALL clear the valid flag.
REQ-030 Without AES_DEC_KEY_CACHE_EN, the cache storage SHALL be absent and every block SHALL take 21 cycles.

Structure
REQ-031 Package aes_pkg SHALL hold NK, NR, the Rcon table, the S-box and inverse S-box functions, the xtime/gmul functions, and the FSM state enum.
REQ-032 The single sub-module inv_round SHALL be combinational: inputs state, round_key and a last flag; output the next state.
REQ-033 Forward and inverse key-step functions SHALL live in aes_pkg.

Verification
REQ-034 FIPS-197 C.1 decryption SHALL be checked: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff and done exactly 21 cycles after accept.
REQ-035 FIPS-197 Appendix B SHALL be checked: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-036 The bench SHALL pulse start again 5 cycles after accept with different data -> one done only, carrying the original result.
REQ-037 The bench SHALL assert reset at cycle 12 of a block -> busy=0, data_out=0, no done; then re-run C.1 -> correct result.
REQ-038 The bench SHALL hold start high through done for back-to-back C.1 then B -> two done pulses 21 cycles apart.
REQ-039 With AES_DEC_KEY_CACHE_EN defined, the bench SHALL issue C.1 twice with the same key -> latency 21 then 11; then the B key -> latency 21.
